free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 97 +++++++++
 tb/tb_free_list.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for a 2-wide rename stage.
// Speculative (head), retired (commit_head) and release (tail) pointers allow flush recovery.
module free_list #(
  parameter int PHY_REGS  = 64,
  parameter int ARCH_REGS = 32,
  parameter int PHY_WIDTH = 6,
  parameter int DEPTH     = PHY_REGS - ARCH_REGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [1:0]           alloc_req,
  output logic                 alloc_gnt,
  output logic [PHY_WIDTH-1:0] alloc_phy_0,
  output logic [PHY_WIDTH-1:0] alloc_phy_1,
  output logic [1:0]           busy_valid,
  output logic [PHY_WIDTH-1:0] rd_phy_busy_0,
  output logic [PHY_WIDTH-1:0] rd_phy_busy_1,
  input  logic                 retire_valid,
  input  logic                 retire_alloc,
  input  logic [PHY_WIDTH-1:0] rd_phy_old_commit,
  output logic [PHY_WIDTH-1:0] free_count,
  output logic                 empty,
  output logic                 overflow_err
);

  // DEPTH is assumed to be a power of two so index arithmetic wraps naturally.
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PHY_WIDTH-1:0] fifo [DEPTH];
  logic [PW-1:0]        head, commit_head, tail;

  logic [1:0]           n_req;
  logic [IW-1:0]        head_idx, head_idx_p1;
  logic                 release_req, commit_adv, storage_full, do_write, ovf_set;
  logic [PW-1:0]        commit_head_nxt, tail_nxt, head_nxt;
  logic [PHY_WIDTH-1:0] n_granted, free_nxt;

  always_comb begin
    n_req       = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
    alloc_gnt   = rst_n && !flush && (n_req != 2'd0) && (free_count >= PHY_WIDTH'(n_req));
    busy_valid  = alloc_req & {2{alloc_gnt}};

    head_idx    = head[IW-1:0];
    head_idx_p1 = head_idx + IW'(1);
    alloc_phy_0 = fifo[head_idx];
    alloc_phy_1 = alloc_req[0] ? fifo[head_idx_p1] : fifo[head_idx];
    rd_phy_busy_0 = alloc_phy_0;
    rd_phy_busy_1 = alloc_phy_1;

    release_req     = retire_valid && (rd_phy_old_commit != '0);
    commit_adv      = retire_valid && retire_alloc;
    commit_head_nxt = commit_head + PW'(commit_adv);
    // A simultaneous retire vacates the slot at commit_head, so it counts before the full test.
    storage_full    = (tail - commit_head_nxt) == PW'(DEPTH);
    do_write        = release_req && !storage_full;
    ovf_set         = release_req && storage_full;
    tail_nxt        = tail + PW'(do_write);

    n_granted = alloc_gnt ? PHY_WIDTH'(n_req) : '0;
    if (flush) begin
      head_nxt = commit_head_nxt;
      free_nxt = PHY_WIDTH'(tail_nxt - commit_head_nxt);
    end else begin
      head_nxt = head + PW'(n_granted);
      free_nxt = free_count - n_granted + PHY_WIDTH'(do_write);
    end

    empty = (free_count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i] <= PHY_WIDTH'(ARCH_REGS + i);
      end
      head         <= '0;
      commit_head  <= '0;
      tail         <= PW'(DEPTH);
      free_count   <= PHY_WIDTH'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      if (do_write) begin
        fifo[tail[IW-1:0]] <= rd_phy_old_commit;
      end
      head        <= head_nxt;
      commit_head <= commit_head_nxt;
      tail        <= tail_nxt;
      free_count  <= free_nxt;
      if (ovf_set) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] alloc_req = 2'b00;
  logic       alloc_gnt;
  logic [5:0] alloc_phy_0, alloc_phy_1, rd_phy_busy_0, rd_phy_busy_1;
  logic [1:0] busy_valid;
  logic       retire_valid = 1'b0;
  logic       retire_alloc = 1'b0;
  logic [5:0] rd_phy_old_commit = '0;
  logic [5:0] free_count;
  logic       empty, overflow_err;

  free_list dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_req(alloc_req),
    .alloc_gnt(alloc_gnt), .alloc_phy_0(alloc_phy_0), .alloc_phy_1(alloc_phy_1),
    .busy_valid(busy_valid), .rd_phy_busy_0(rd_phy_busy_0), .rd_phy_busy_1(rd_phy_busy_1),
    .retire_valid(retire_valid), .retire_alloc(retire_alloc),
    .rd_phy_old_commit(rd_phy_old_commit), .free_count(free_count),
    .empty(empty), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // -1 in a field means "not checked this cycle"
  typedef struct {
    int gnt; int p0; int p1; int bv; int fc; int emp; int ovf;
  } exp_t;

  exp_t  sb_q [$];
  string name_q [$];
  int    tests = 0;
  int    fails = 0;

  task automatic cmp(input string nm, input string field, input int act, input int exp);
    if (exp >= 0) begin
      tests++;
      if (act != exp) begin
        fails++;
        $display("FAIL %s.%s actual=%0d expected=%0d", nm, field, act, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, "alloc_gnt", int'(alloc_gnt), e.gnt);
      cmp(nm, "alloc_phy_0", int'(alloc_phy_0), e.p0);
      cmp(nm, "alloc_phy_1", int'(alloc_phy_1), e.p1);
      cmp(nm, "busy_valid", int'(busy_valid), e.bv);
      cmp(nm, "free_count", int'(free_count), e.fc);
      cmp(nm, "empty", int'(empty), e.emp);
      cmp(nm, "overflow_err", int'(overflow_err), e.ovf);
      if (e.p0 >= 0) cmp(nm, "rd_phy_busy_0", int'(rd_phy_busy_0), e.p0);
      if (e.p1 >= 0) cmp(nm, "rd_phy_busy_1", int'(rd_phy_busy_1), e.p1);
    end
  end

  task automatic drive(input logic rst, input logic [1:0] req, input logic fl,
                       input logic rv, input logic ra, input logic [5:0] old,
                       input string nm, input int gnt, input int p0, input int p1,
                       input int bv, input int fc, input int emp, input int ovf);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; alloc_req = req; flush = fl;
    retire_valid = rv; retire_alloc = ra; rd_phy_old_commit = old;
    e.gnt = gnt; e.p0 = p0; e.p1 = p1; e.bv = bv; e.fc = fc; e.emp = emp; e.ovf = ovf;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input string nm);
    drive(0, 2'b11, 0, 0, 0, 6'd0, nm, 0, -1, -1, 0, 32, 0, 0);
  endtask

  task automatic idle(input string nm, input int fc, input int emp, input int ovf);
    drive(1, 2'b00, 0, 0, 0, 6'd0, nm, 0, -1, -1, 0, fc, emp, ovf);
  endtask

  initial begin
    // Dual allocation from reset
    do_reset("rst_a");
    drive(1, 2'b11, 0, 0, 0, 6'd0, "dual", 1, 32, 33, 3, 32, 0, 0);
    idle("dual_fc", 30, 0, 0);

    // Mid-operation reset, then slot-1-only followed by slot-0-only
    do_reset("rst_b");
    drive(1, 2'b10, 0, 0, 0, 6'd0, "slot1_only", 1, -1, 32, 2, 32, 0, 0);
    drive(1, 2'b01, 0, 0, 0, 6'd0, "slot0_only", 1, 33, -1, 1, 31, 0, 0);
    idle("single_fc", 30, 0, 0);

    // Drain all 32 tags, then release into an empty list
    do_reset("rst_c");
    for (int k = 0; k < 16; k++)
      drive(1, 2'b11, 0, 0, 0, 6'd0, "fill", 1, 32 + 2*k, 33 + 2*k, 3, 32 - 2*k, 0, 0);
    drive(1, 2'b01, 0, 1, 1, 6'd5, "empty_block", 0, -1, -1, 0, 0, 1, 0);
    drive(1, 2'b01, 0, 0, 0, 6'd0, "reuse5", 1, 5, -1, 1, 1, 0, 0);
    idle("after_reuse", 0, 1, 0);

    // No partial grant with one tag left
    drive(1, 2'b00, 0, 1, 1, 6'd6, "rel6", 0, -1, -1, 0, 0, 1, 0);
    drive(1, 2'b11, 0, 0, 0, 6'd0, "no_partial", 0, -1, -1, 0, 1, 0, 0);
    drive(1, 2'b01, 0, 0, 0, 6'd0, "head_same", 1, 6, -1, 1, 1, 0, 0);
    idle("after_6", 0, 1, 0);

    // Flush reclaims speculative tags; release in flush cycle lands at tail
    do_reset("rst_d");
    drive(1, 2'b11, 0, 0, 0, 6'd0, "fa0", 1, 32, 33, 3, 32, 0, 0);
    drive(1, 2'b11, 0, 0, 0, 6'd0, "fa1", 1, 34, 35, 3, 30, 0, 0);
    drive(1, 2'b00, 0, 1, 1, 6'd7, "ret7", 0, -1, -1, 0, 28, 0, 0);
    drive(1, 2'b01, 1, 0, 0, 6'd0, "flush", 0, -1, -1, 0, 29, 0, 0);
    drive(1, 2'b01, 0, 0, 0, 6'd0, "post_flush", 1, 33, -1, 1, 32, 0, 0);
    idle("post_flush_fc", 31, 0, 0);

    // Zero-tag release is ignored; release when full sets sticky error
    do_reset("rst_e");
    drive(1, 2'b00, 0, 1, 0, 6'd0, "rel_zero", 0, -1, -1, 0, 32, 0, 0);
    drive(1, 2'b00, 0, 1, 0, 6'd9, "rel_full", 0, -1, -1, 0, 32, 0, 0);
    drive(1, 2'b01, 0, 0, 0, 6'd0, "ovf_alloc", 1, 32, -1, 1, 32, 0, 1);
    idle("ovf_sticky", 31, 0, 1);
    do_reset("rst_f");
    idle("ovf_cleared", 32, 0, 0);

    @(posedge clk);
    #1;
    retire_valid = 1'b0;
    alloc_req = 2'b00;
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
